// File: rtl/window_gen.sv
// window_gen: streams a raster image in and emits every fully-populated 3x3
// neighbourhood. Two line buffers hold the previous two rows; a 3x3 register
// slides one column per accepted pixel. Windows are only produced for pixel
// positions with row >= 2 and col >= 2, so none straddle a line boundary.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start_i             one-cycle pulse, latches cfg_cols_i/cfg_rows_i
//   cfg_cols_i/rows_i   image width/height in pixels
//   pix_i/pix_valid_i   input pixel stream, pix_ready_o backpressure
//   win_o/win_valid_o   3x3 window (element (i,j) at [(3i+j)*DATA_W +: DATA_W])
//   win_ready_i         consumer backpressure
//   busy_o              frame in progress
//   frame_done_o        pulse after the last window of a frame is taken
//   err_o               pulse on a start with an unusable configuration
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | accepting pixels, producing windows
// DONE  | all pixels taken, draining the last window
module window_gen #(
  parameter int DATA_W  = 8,
  parameter int MAX_COL = 540,
  parameter int CNT_W   = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [CNT_W-1:0]      cfg_cols_i,
  input  logic [CNT_W-1:0]      cfg_rows_i,
  input  logic [DATA_W-1:0]     pix_i,
  input  logic                  pix_valid_i,
  output logic                  pix_ready_o,
  output logic [9*DATA_W-1:0]   win_o,
  output logic                  win_valid_o,
  input  logic                  win_ready_i,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  err_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] MAX_COL_C = CNT_W'(MAX_COL);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);
  localparam logic [CNT_W-1:0] THREE     = CNT_W'(3);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cols_q;
  logic [CNT_W-1:0]  rows_q;
  logic [CNT_W-1:0]  row_cnt;
  logic [CNT_W-1:0]  col_cnt;
  logic              win_valid_q;
  logic              frame_done_q;
  logic              err_q;

  logic [DATA_W-1:0] line_a [MAX_COL];
  logic [DATA_W-1:0] line_b [MAX_COL];
  logic [DATA_W-1:0] win_q  [3][3];

  logic pix_xfer;
  logic win_xfer;
  logic cfg_ok;
  logic last_col;
  logic last_row;
  logic win_hit;

  // A pixel may only enter when the window register is free or being emptied
  // this cycle, which keeps win_o stable while the consumer stalls.
  assign pix_ready_o = (state == RUN) && (!win_valid_q || win_ready_i);
  assign pix_xfer    = pix_valid_i && pix_ready_o;
  assign win_xfer    = win_valid_q && win_ready_i;

  assign cfg_ok   = (cfg_cols_i >= THREE) && (cfg_cols_i <= MAX_COL_C) &&
                    (cfg_rows_i >= THREE);
  assign last_col = (col_cnt == cols_q - ONE);
  assign last_row = (row_cnt == rows_q - ONE);
  assign win_hit  = (row_cnt >= TWO) && (col_cnt >= TWO);

  assign win_valid_o  = win_valid_q;
  assign frame_done_o = frame_done_q;
  assign err_o        = err_q;
  assign busy_o       = (state == RUN) || (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cols_q       <= '0;
      rows_q       <= '0;
      row_cnt      <= '0;
      col_cnt      <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;

      if (pix_xfer && win_hit)
        win_valid_q <= 1'b1;
      else if (win_xfer)
        win_valid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (start_i) begin
            if (cfg_ok) begin
              cols_q  <= cfg_cols_i;
              rows_q  <= cfg_rows_i;
              row_cnt <= '0;
              col_cnt <= '0;
              state   <= RUN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (pix_xfer) begin
            if (last_col) begin
              col_cnt <= '0;
              // Row counter returns to 0 on the final pixel so it never
              // reaches the latched row limit.
              if (last_row) begin
                row_cnt <= '0;
                state   <= DONE;
              end else begin
                row_cnt <= row_cnt + ONE;
              end
            end else begin
              col_cnt <= col_cnt + ONE;
            end
          end
        end
        DONE: begin
          if (!win_valid_q || win_ready_i) begin
            frame_done_q <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage only; contents are meaningless until refilled by a new frame.
  always_ff @(posedge clk) begin
    if (pix_xfer) begin
      line_b[col_cnt] <= line_a[col_cnt];
      line_a[col_cnt] <= pix_i;
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= win_q[i][1];
        win_q[i][1] <= win_q[i][2];
      end
      win_q[0][2] <= line_b[col_cnt];
      win_q[1][2] <= line_a[col_cnt];
      win_q[2][2] <= pix_i;
    end
  end

  always_comb begin
    win_o = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        win_o[(3*i+j)*DATA_W +: DATA_W] = win_q[i][j];
      end
    end
  end

endmodule
